cache_refill_ctrl: RTL and testbench

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

---
 rtl/cache_refill_ctrl.sv | 132 +++++++++++++
 tb/tb_cache_refill_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// cache_refill_ctrl: fetches one cache line as BEATS response beats and writes it to the data array.
// Optional critical-word forward port enabled by defining CACHE_REFILL_CRIT_FWD_EN.
module cache_refill_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int BEAT_WIDTH = 64,
    parameter int BEATS      = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [ADDR_WIDTH-1:0]         req_addr_i,
    output logic                          mem_req_valid_o,
    input  logic                          mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]         mem_req_addr_o,
    input  logic                          mem_resp_valid_i,
    output logic                          mem_resp_ready_o,
    input  logic [BEAT_WIDTH-1:0]         mem_resp_data_i,
    output logic                          line_wr_valid_o,
    input  logic                          line_wr_ready_i,
    output logic [ADDR_WIDTH-1:0]         line_wr_addr_o,
    output logic [BEATS*BEAT_WIDTH-1:0]   line_wr_data_o,
`ifdef CACHE_REFILL_CRIT_FWD_EN
    output logic                          fwd_valid_o,
    output logic [BEAT_WIDTH-1:0]         fwd_data_o,
`endif
    output logic                          busy_o
);

    localparam int OFF  = $clog2(BEATS * BEAT_WIDTH / 8);
    localparam int BOFF = $clog2(BEAT_WIDTH / 8);
    localparam int CW   = $clog2(BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MREQ  = 2'd1,
        FILL  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t                        state_q;
    logic [CW-1:0]                 beat_cnt_q;
    logic [CW-1:0]                 beat_cnt_d;
    logic [ADDR_WIDTH-1:0]         addr_q;
    logic [BEATS*BEAT_WIDTH-1:0]   line_q;
    logic [ADDR_WIDTH-1:0]         line_addr;
    logic                          unused_addr_bits;

    assign beat_cnt_d       = beat_cnt_q + CW'(1);
    assign line_addr        = {addr_q[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
    // Offset bits inside the line only matter for critical-word selection.
    assign unused_addr_bits = ^addr_q[OFF-1:0];

    assign req_ready_o      = (state_q == IDLE);
    assign busy_o           = (state_q != IDLE);
    assign mem_req_valid_o  = (state_q == MREQ);
    assign mem_req_addr_o   = line_addr;
    assign mem_resp_ready_o = (state_q == FILL);
    assign line_wr_valid_o  = (state_q == WRITE);
    assign line_wr_addr_o   = line_addr;
    assign line_wr_data_o   = line_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            addr_q     <= '0;
            line_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q  <= req_addr_i;
                        state_q <= MREQ;
                    end
                end
                MREQ: begin
                    if (mem_req_ready_i) begin
                        beat_cnt_q <= '0;
                        state_q    <= FILL;
                    end
                end
                FILL: begin
                    if (mem_resp_valid_i) begin
                        for (int k = 0; k < BEATS; k++) begin
                            if (beat_cnt_q == CW'(k)) begin
                                line_q[k*BEAT_WIDTH +: BEAT_WIDTH] <= mem_resp_data_i;
                            end
                        end
                        beat_cnt_q <= beat_cnt_d;
                        if (beat_cnt_q == LAST_BEAT) begin
                            state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (line_wr_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CACHE_REFILL_CRIT_FWD_EN
    logic                  fwd_valid_q;
    logic [BEAT_WIDTH-1:0] fwd_data_q;
    logic [CW-1:0]         crit_idx;

    assign crit_idx    = addr_q[OFF-1:BOFF];
    assign fwd_valid_o = fwd_valid_q;
    assign fwd_data_o  = fwd_data_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            fwd_valid_q <= 1'b0;
            if (state_q == FILL && mem_resp_valid_i && beat_cnt_q == crit_idx) begin
                fwd_valid_q <= 1'b1;
                fwd_data_q  <= mem_resp_data_i;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// tb_cache_refill_ctrl: vector-table and scoreboard bench for cache_refill_ctrl (default parameters).
module tb_cache_refill_ctrl;

    logic          clk;
    logic          rstn;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [31:0]   req_addr_i;
    logic          mem_req_valid_o;
    logic          mem_req_ready_i;
    logic [31:0]   mem_req_addr_o;
    logic          mem_resp_valid_i;
    logic          mem_resp_ready_o;
    logic [63:0]   mem_resp_data_i;
    logic          line_wr_valid_o;
    logic          line_wr_ready_i;
    logic [31:0]   line_wr_addr_o;
    logic [255:0]  line_wr_data_o;
    logic          busy_o;
`ifdef CACHE_REFILL_CRIT_FWD_EN
    logic          fwd_valid_o;
    logic [63:0]   fwd_data_o;
`endif

    cache_refill_ctrl dut (
        .clk              (clk),
        .rstn             (rstn),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_addr_i       (req_addr_i),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_ready_o (mem_resp_ready_o),
        .mem_resp_data_i  (mem_resp_data_i),
        .line_wr_valid_o  (line_wr_valid_o),
        .line_wr_ready_i  (line_wr_ready_i),
        .line_wr_addr_o   (line_wr_addr_o),
        .line_wr_data_o   (line_wr_data_o),
`ifdef CACHE_REFILL_CRIT_FWD_EN
        .fwd_valid_o      (fwd_valid_o),
        .fwd_data_o       (fwd_data_o),
`endif
        .busy_o           (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       addr;
        logic [3:0][63:0]  beat;
        int                mstall;
        int                wstall;
        bit                gap;
        logic [31:0]       exp_maddr;
        logic [255:0]      exp_line;
    } vec_t;

    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

    vec_t          vt [4];
    logic [31:0]   exp_addr_q [$];
    logic [255:0]  exp_line_q [$];
    int            n_vec = 0;
    int            n_err = 0;
    bit            rr_high;
    int            fwd_cnt = 0;
    logic [63:0]   fwd_last;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        rr_high = rr_high | req_ready_o;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a line write is about to complete at the next rising edge.
    always @(negedge clk) begin
        if (rstn && line_wr_valid_o && line_wr_ready_i) begin
            if (exp_line_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got addr %h expected no write", line_wr_addr_o);
            end else begin
                check("wr_addr", line_wr_addr_o, exp_addr_q.pop_front());
                check("wr_data", line_wr_data_o, exp_line_q.pop_front());
            end
        end
`ifdef CACHE_REFILL_CRIT_FWD_EN
        if (rstn && fwd_valid_o) begin
            fwd_cnt++;
            fwd_last = fwd_data_o;
        end
`endif
    end

    task automatic request(input logic [31:0] addr);
        int n;
        n = 0;
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        while (!req_ready_o && n < 50) begin
            step();
            n++;
        end
        if (n == 50) check("req_timeout", 1'b0, 1'b1);
        step();
        req_valid_i = 1'b0;
    endtask

    // Drives MREQ/FILL/WRITE phases of vector idx; the request was already accepted.
    task automatic body(input int idx);
        vec_t v;
        v = vt[idx];
        exp_addr_q.push_back(v.exp_maddr);
        exp_line_q.push_back(v.exp_line);
        fwd_cnt = 0;
        for (int s = 0; s <= v.mstall; s++) begin
            mem_req_ready_i  = (s == v.mstall);
            mem_resp_valid_i = 1'b1;
            mem_resp_data_i  = JUNK;
            check("mreq_valid", mem_req_valid_o, 1'b1);
            check("mreq_addr", mem_req_addr_o, v.exp_maddr);
            check("resp_rdy_mreq", mem_resp_ready_o, 1'b0);
            step();
        end
        mem_req_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_resp_valid_i = 1'b1;
            mem_resp_data_i  = v.beat[k];
            check("resp_rdy_fill", mem_resp_ready_o, 1'b1);
            step();
            if (v.gap && k < 3) begin
                mem_resp_valid_i = 1'b0;
                mem_resp_data_i  = JUNK;
                step();
            end
        end
        for (int s = 0; s <= v.wstall; s++) begin
            line_wr_ready_i  = (s == v.wstall);
            mem_resp_valid_i = (s < v.wstall);
            mem_resp_data_i  = JUNK;
            check("wr_valid", line_wr_valid_o, 1'b1);
            check("wr_addr_hold", line_wr_addr_o, v.exp_maddr);
            check("wr_data_hold", line_wr_data_o, v.exp_line);
            step();
        end
        line_wr_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        check("busy_after_wr", busy_o, 1'b0);
`ifdef CACHE_REFILL_CRIT_FWD_EN
        check("fwd_cnt", 32'(fwd_cnt), 32'd1);
        check("fwd_data", fwd_last, v.beat[v.addr[4:3]]);
`endif
    endtask

    initial begin
        int cyc;
        int bi;
        bit done;
        bit adv;

        vt[0].addr = 32'h1234_5678; vt[0].mstall = 0; vt[0].wstall = 0; vt[0].gap = 1'b0;
        vt[0].beat = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        vt[0].exp_maddr = 32'h1234_5660;
        vt[0].exp_line  = {64'hA3, 64'hA2, 64'hA1, 64'hA0};

        vt[1].addr = 32'hFFFF_FFFF; vt[1].mstall = 3; vt[1].wstall = 5; vt[1].gap = 1'b0;
        vt[1].beat = {64'h8000_0000_0000_0001, 64'h0123_4567_89AB_CDEF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        vt[1].exp_maddr = 32'hFFFF_FFE0;
        vt[1].exp_line  = {64'h8000_0000_0000_0001, 64'h0123_4567_89AB_CDEF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};

        vt[2].addr = 32'h0000_001F; vt[2].mstall = 0; vt[2].wstall = 0; vt[2].gap = 1'b1;
        vt[2].beat = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        vt[2].exp_maddr = 32'h0000_0000;
        vt[2].exp_line  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

        vt[3].addr = 32'h8000_0030; vt[3].mstall = 1; vt[3].wstall = 1; vt[3].gap = 1'b1;
        vt[3].beat = {64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0002,
                      64'hC0DE_0000_0000_0001, 64'hC0DE_0000_0000_0000};
        vt[3].exp_maddr = 32'h8000_0020;
        vt[3].exp_line  = {64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0002,
                           64'hC0DE_0000_0000_0001, 64'hC0DE_0000_0000_0000};

        rstn = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; mem_req_ready_i = 1'b0;
        mem_resp_valid_i = 1'b0; mem_resp_data_i = '0; line_wr_ready_i = 1'b0;
        rr_high = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy_o, 1'b0);
        check("rst_mreq_valid", mem_req_valid_o, 1'b0);
        check("rst_wr_valid", line_wr_valid_o, 1'b0);
        rstn = 1'b1;
        step();
        check("rst_req_ready", req_ready_o, 1'b1);
        check("rst_resp_ready", mem_resp_ready_o, 1'b0);
        check("rst_line_data", line_wr_data_o, 256'h0);

        for (int i = 0; i < 4; i++) begin
            request(vt[i].addr);
            body(i);
        end

        // Minimum latency with every ready held high.
        exp_addr_q.push_back(vt[0].exp_maddr);
        exp_line_q.push_back(vt[0].exp_line);
        mem_req_ready_i = 1'b1; line_wr_ready_i = 1'b1; mem_resp_valid_i = 1'b1;
        bi = 0;
        mem_resp_data_i = vt[0].beat[0];
        req_valid_i = 1'b1; req_addr_i = vt[0].addr;
        step();
        req_valid_i = 1'b0;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 50) begin
            done = line_wr_valid_o;
            adv  = mem_resp_ready_o;
            step();
            cyc++;
            if (adv && bi < 3) begin
                bi++;
                mem_resp_data_i = vt[0].beat[bi];
            end
        end
        check("latency", 32'(cyc), 32'd6);
        mem_req_ready_i = 1'b0; line_wr_ready_i = 1'b0; mem_resp_valid_i = 1'b0;

        // Back-to-back: second request held high during the first refill.
        req_valid_i = 1'b1; req_addr_i = vt[2].addr;
        step();
        req_addr_i = vt[3].addr;
        rr_high = 1'b0;
        body(2);
        check("b2b_ready_low", rr_high, 1'b0);
        check("b2b_ready_after", req_ready_o, 1'b1);
        step();
        req_valid_i = 1'b0;
        check("b2b_second_busy", busy_o, 1'b1);
        body(3);

        // Reset after two beats of FILL abandons the refill.
        request(vt[1].addr);
        mem_req_ready_i = 1'b1;
        step();
        mem_req_ready_i = 1'b0;
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i = vt[1].beat[0];
        step();
        mem_resp_data_i = vt[1].beat[1];
        step();
        mem_resp_valid_i = 1'b0;
        rstn = 1'b0;
        #1;
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_wr_valid", line_wr_valid_o, 1'b0);
        check("midrst_resp_ready", mem_resp_ready_o, 1'b0);
        step();
        step();
        rstn = 1'b1;
        line_wr_ready_i = 1'b1;
        repeat (3) step();
        line_wr_ready_i = 1'b0;
        check("midrst_no_write", line_wr_valid_o, 1'b0);
        check("midrst_ready", req_ready_o, 1'b1);
        check("midrst_line_clr", line_wr_data_o, 256'h0);
        request(vt[2].addr);
        body(2);

        repeat (2) step();
        check("sb_empty", 32'(exp_line_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
